// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   Pipeline register and load-return unit between MEM and register-file
//   writeback of the 5-stage RV32I core. Non-load results are written back
//   one cycle after acceptance. A load parks the stage in WAIT, with upstream
//   stalled, until the data-memory response arrives. The addressed
//   byte/halfword/word is then extracted and sign- or zero-extended.
//
//   Optional feature macro: LOAD_TIMEOUT_EN
//     When defined, a load still waiting after TIMEOUT_CYCLES WAIT cycles is
//     abandoned. The stage then produces a non-writing wb pulse with data
//     32'hDEAD_BEEF and a one-cycle load_err pulse. When undefined, WAIT lasts
//     until d_ready and load_err is constant 0.
//
// Ports
//   clk          core clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_valid     MEM stage presents a valid instruction
//   opcode       RV32I opcode of the presented instruction
//   funct3       load width/sign (LB/LH/LW/LBU/LHU; 011/110/111 act as LW)
//   rd           destination register
//   res          ALU result (byte address for loads)
//   load_shift   byte offset within the word
//   d_data_read  data-memory read word
//   d_ready      d_data_read valid this cycle
//   stall_req    upstream must hold (high while in WAIT)
//   wb_valid     one-cycle pulse per retired instruction
//   wb_rd        writeback register
//   wb_data      writeback value
//   wb_we        register-file write enable
//   load_err     one-cycle pulse when a load is abandoned
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [31:0] res,
  input  logic [1:0]  load_shift,
  input  logic [31:0] d_data_read,
  input  logic        d_ready,
  output logic        stall_req,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic        load_err
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  logic [4:0]  lat_rd_r;
  logic [2:0]  lat_funct3_r;
  logic [1:0]  lat_shift_r;

  logic        wb_valid_r;
  logic [4:0]  wb_rd_r;
  logic [31:0] wb_data_r;
  logic        wb_we_r;
  logic        load_err_r;

  logic        wb_valid_nxt_s;
  logic [4:0]  wb_rd_nxt_s;
  logic [31:0] wb_data_nxt_s;
  logic        wb_we_nxt_s;
  logic        load_err_nxt_s;

  logic        accept_load_s;
  logic        timeout_s;

  // Selects and extends the addressed byte/halfword of a load response.
  // A misaligned halfword at offset 3 naturally sees zeros above byte 3.
  function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                               input logic [1:0]  sh,
                                               input logic [31:0] word);
    logic [31:0] s;
    s = word >> {sh, 3'b000};
    case (f3)
      3'b000:  extract_load = {{24{s[7]}}, s[7:0]};
      3'b001:  extract_load = {{16{s[15]}}, s[15:0]};
      3'b100:  extract_load = {24'h00_0000, s[7:0]};
      3'b101:  extract_load = {16'h0000, s[15:0]};
      default: extract_load = word;
    endcase
  endfunction

  // Opcodes whose result is architecturally written to rd.
  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  endfunction

  // A load is only accepted from IDLE; d_ready in that same cycle is ignored.
  assign accept_load_s = (state_r == ST_IDLE) && in_valid && (opcode == OPC_LOAD);

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0] wait_cnt_r;

  // Counts WAIT cycles without a response; restarts on each accepted load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_load_s) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_WAIT) && !d_ready) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // The count includes the current cycle, so the load is abandoned at the
  // end of the TIMEOUT_CYCLES-th WAIT cycle; a same-cycle d_ready wins.
  assign timeout_s = (state_r == ST_WAIT) && !d_ready &&
                     (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 32'd1));
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_load_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (d_ready || timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the writeback registers; rd/data/we hold when no pulse.
  always_comb begin
    wb_valid_nxt_s = 1'b0;
    wb_rd_nxt_s    = wb_rd_r;
    wb_data_nxt_s  = wb_data_r;
    wb_we_nxt_s    = wb_we_r;
    load_err_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && (opcode != OPC_LOAD)) begin
          wb_valid_nxt_s = 1'b1;
          wb_rd_nxt_s    = rd;
          wb_data_nxt_s  = res;
          wb_we_nxt_s    = writes_rd(opcode) && (rd != 5'd0);
        end else begin
          wb_valid_nxt_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (d_ready) begin
          wb_valid_nxt_s = 1'b1;
          wb_rd_nxt_s    = lat_rd_r;
          wb_data_nxt_s  = extract_load(lat_funct3_r, lat_shift_r, d_data_read);
          wb_we_nxt_s    = (lat_rd_r != 5'd0);
        end else if (timeout_s) begin
          wb_valid_nxt_s = 1'b1;
          wb_rd_nxt_s    = lat_rd_r;
          wb_data_nxt_s  = 32'hDEAD_BEEF;
          wb_we_nxt_s    = 1'b0;
          load_err_nxt_s = 1'b1;
        end else begin
          wb_valid_nxt_s = 1'b0;
        end
      end
      default: begin
        wb_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered writeback outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_r <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_data_r  <= 32'd0;
      wb_we_r    <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      wb_valid_r <= wb_valid_nxt_s;
      wb_rd_r    <= wb_rd_nxt_s;
      wb_data_r  <= wb_data_nxt_s;
      wb_we_r    <= wb_we_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  // Load descriptor captured when the load leaves MEM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_rd_r     <= 5'd0;
      lat_funct3_r <= 3'd0;
      lat_shift_r  <= 2'd0;
    end else if (accept_load_s) begin
      lat_rd_r     <= rd;
      lat_funct3_r <= funct3;
      lat_shift_r  <= load_shift;
    end else begin
      lat_rd_r     <= lat_rd_r;
      lat_funct3_r <= lat_funct3_r;
      lat_shift_r  <= lat_shift_r;
    end
  end

  assign stall_req = (state_r == ST_WAIT);
  assign wb_valid  = wb_valid_r;
  assign wb_rd     = wb_rd_r;
  assign wb_data   = wb_data_r;
  assign wb_we     = wb_we_r;
  assign load_err  = load_err_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

`ifdef LOAD_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  localparam logic [6:0] LOAD = 7'b0000011;
  localparam logic [6:0] OPR  = 7'b0110011;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] res;
  logic [1:0]  load_shift;
  logic [31:0] d_data_read;
  logic        d_ready;
  logic        stall_req;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_we;
  logic        load_err;

  mem_wb_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .opcode(opcode),
    .funct3(funct3), .rd(rd), .res(res), .load_shift(load_shift),
    .d_data_read(d_data_read), .d_ready(d_ready), .stall_req(stall_req),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;   // WAIT cycle (1-based) on which memory answers
    logic [31:0] data;
  } instr_t;

  int checks = 0;
  int errors = 0;

  // expectations for the coming rising edge, produced by the model
  logic        chk_en;
  logic        exp_valid, exp_we, exp_err, exp_stall;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;

  instr_t dq[$];
  instr_t cur, p;
  bit     pend, consumed;
  int     pw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference load extraction in plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] sh,
                                           input logic [31:0] w);
    longint unsigned s, b, h;
    s = longint'(w) / (longint'(1) << (8 * int'(sh)));
    b = s % 256;
    h = s % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'b001:  return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic bit ref_writes(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
  endfunction

  function automatic instr_t mk(input logic v, input logic [6:0] op, input logic [2:0] f3,
                                input logic [4:0] r, input logic [31:0] rs, input int lat,
                                input logic [31:0] data);
    instr_t t;
    t.v = v; t.op = op; t.f3 = f3; t.rd = r; t.res = rs; t.lat = lat; t.data = data;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    logic [6:0] ops [11];
    instr_t t;
    int idx;
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b0100011, 7'b1100011, 7'b1110011, 7'b0001111, 7'b1111111};
    idx = int'($urandom_range(0, 15));
    t.v    = ($urandom_range(0, 7) != 0);
    t.op   = (idx >= 11) ? LOAD : ops[idx];
    t.f3   = 3'($urandom_range(0, 7));
    t.rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    t.res  = $urandom;
    t.lat  = int'($urandom_range(1, 6));
    t.data = $urandom;
    return t;
  endfunction

  // Compare process: checks DUT outputs just after every rising edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("stall_req", 32'(stall_req), 32'(exp_stall));
      chk("wb_valid", 32'(wb_valid), 32'(exp_valid));
      chk("load_err", 32'(load_err), 32'(exp_err));
      if (exp_valid) begin
        chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
        chk("wb_data", wb_data, exp_data);
        chk("wb_we", 32'(wb_we), 32'(exp_we));
      end
    end
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; opcode = 7'd0; funct3 = 3'd0; rd = 5'd0;
    res = 32'd0; load_shift = 2'd0; d_data_read = 32'd0; d_ready = 1'b0;
    chk_en = 1'b0; pend = 1'b0; consumed = 1'b1; pw = 0;
    exp_valid = 1'b0; exp_we = 1'b0; exp_err = 1'b0; exp_stall = 1'b0;
    exp_rd = 5'd0; exp_data = 32'd0;

    // pin the model to hand-computed values
    chk("pin_lb", ref_load(3'b000, 2'd2, 32'h0080_FF11), 32'hFFFF_FF80);
    chk("pin_lhu", ref_load(3'b101, 2'd2, 32'h8001_0000), 32'h0000_8001);
    chk("pin_lh", ref_load(3'b001, 2'd2, 32'h8001_0000), 32'hFFFF_8001);
    chk("pin_lw", ref_load(3'b010, 2'd1, 32'hCAFE_BABE), 32'hCAFE_BABE);
    chk("pin_lh_sh3", ref_load(3'b001, 2'd3, 32'h80FF_0000), 32'h0000_0080);

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_rd", 32'(wb_rd), 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_we", 32'(wb_we), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    reset_n = 1'b1;

    // reset in the middle of a pending LW, then a stale d_ready
    @(negedge clk);
    in_valid = 1'b1; opcode = LOAD; funct3 = 3'b010; rd = 5'd7; res = 32'h100;
    @(negedge clk);
    in_valid = 1'b0;
    chk("midwait_stall", 32'(stall_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_stall", 32'(stall_req), 32'd0);
    chk("async_rst_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; d_ready = 1'b1; d_data_read = 32'h1234_5678;
    @(posedge clk);
    #1;
    chk("stale_valid", 32'(wb_valid), 32'd0);
    chk("stale_stall", 32'(stall_req), 32'd0);
    chk("stale_rd", 32'(wb_rd), 32'd0);
    chk("stale_data", wb_data, 32'd0);
    chk("stale_we", 32'(wb_we), 32'd0);
    chk("stale_err", 32'(load_err), 32'd0);

    // directed sequence, then random traffic
    dq.push_back(mk(1'b1, OPR, 3'b000, 5'd5, 32'h0000_1234, 1, 32'd0));
    dq.push_back(mk(1'b1, OPR, 3'b000, 5'd0, 32'h0000_1234, 1, 32'd0));
    dq.push_back(mk(1'b1, LOAD, 3'b000, 5'd3, 32'h0000_1002, 3, 32'h0080_FF11));
    dq.push_back(mk(1'b1, LOAD, 3'b101, 5'd4, 32'h0000_2002, 2, 32'h8001_0000));
    dq.push_back(mk(1'b1, LOAD, 3'b001, 5'd6, 32'h0000_2002, 2, 32'h8001_0000));
    dq.push_back(mk(1'b1, LOAD, 3'b010, 5'd8, 32'h0000_3001, 1, 32'hCAFE_BABE));
    dq.push_back(mk(1'b1, LOAD, 3'b001, 5'd9, 32'h0000_3003, 2, 32'h80FF_0000));
    dq.push_back(mk(1'b1, LOAD, 3'b010, 5'd10, 32'h0000_4000, 1, 32'h0BAD_F00D));
    dq.push_back(mk(1'b1, OPR, 3'b000, 5'd11, 32'h0000_ABCD, 1, 32'd0));
`ifdef LOAD_TIMEOUT_EN
    dq.push_back(mk(1'b1, LOAD, 3'b010, 5'd12, 32'h0000_5000, 99, 32'h1111_2222));
    dq.push_back(mk(1'b1, LOAD, 3'b010, 5'd13, 32'h0000_6000, TMO, 32'h3333_4444));
`endif

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (consumed) begin
        if (dq.size() > 0) cur = dq.pop_front();
        else cur = rand_instr();
      end
      in_valid = cur.v; opcode = cur.op; funct3 = cur.f3; rd = cur.rd;
      res = cur.res; load_shift = cur.res[1:0];
      d_data_read = $urandom; d_ready = 1'b0;
      exp_valid = 1'b0; exp_err = 1'b0;
      if (pend) begin
        consumed = 1'b0;
        if (pw + 1 == p.lat) begin
          d_ready = 1'b1; d_data_read = p.data;
          exp_valid = 1'b1; exp_rd = p.rd; exp_we = (p.rd != 5'd0);
          exp_data = ref_load(p.f3, p.res[1:0], p.data);
          pend = 1'b0;
`ifdef LOAD_TIMEOUT_EN
        end else if (pw + 1 == TMO) begin
          exp_valid = 1'b1; exp_rd = p.rd; exp_we = 1'b0;
          exp_data = 32'hDEAD_BEEF; exp_err = 1'b1;
          pend = 1'b0;
`endif
        end else begin
          pw++;
        end
      end else begin
        consumed = 1'b1;
        d_ready = 1'($urandom_range(0, 1));
        if (cur.v) begin
          if (cur.op == LOAD) begin
            pend = 1'b1; pw = 0; p = cur;
          end else begin
            exp_valid = 1'b1; exp_rd = cur.rd; exp_data = cur.res;
            exp_we = ref_writes(cur.op) && (cur.rd != 5'd0);
          end
        end
      end
      exp_stall = pend;
      chk_en = 1'b1;
    end
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register and load-return unit between the MEM stage and register-file writeback in the 5-stage RV32I core.
- Registers each retiring instruction's result and destination register.
- For loads, waits for the data-memory response and extracts the addressed byte, halfword or word, sign- or zero-extending it to 32 bits.
- Stalls upstream stages while a load response is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of WAIT cycles before a load is abandoned. Used only with LOAD_TIMEOUT_EN.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  MEM stage presents a valid instruction.
- opcode  in  7  RV32I opcode of the presented instruction.
- funct3  in  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- rd  in  5  destination register.
- res  in  32  ALU result; for loads, the byte address.
- load_shift  in  2  byte offset within the word (res[1:0]).
- d_data_read  in  32  data-memory read word.
- d_ready  in  1  d_data_read is valid this cycle.
- stall_req  out  1  upstream must hold its state and outputs.
- wb_valid  out  1  wb_* fields are valid this cycle (one-cycle pulse per instruction).
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback value.
- wb_we  out  1  register-file write enable.
- load_err  out  1  one-cycle pulse when a load is abandoned. Tied to 0 without LOAD_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; wb_valid=0, wb_rd=0, wb_data=0, wb_we=0, load_err=0, stall_req=0; the internal latch is cleared. A pending load is discarded, and any d_ready arriving after reset deasserts is ignored.
- States: IDLE and WAIT.
- stall_req = (state==WAIT), decoded combinationally from the state register.
- IDLE, in_valid=0:
  - wb_valid=0 on the next edge.
  - wb_rd, wb_data and wb_we hold their values but are don't-care.
- IDLE, in_valid=1, opcode≠LOAD (latency 1):
  - Next edge: wb_valid=1, wb_rd=rd, wb_data=res.
  - wb_we=1 only when opcode is OP, OP_IMM, LUI, AUIPC, JAL or JALR and rd≠0.
  - STORE, BRANCH and any other opcode: wb_valid=1, wb_we=0.
- IDLE, in_valid=1, opcode==LOAD:
  - Latch rd, funct3 and load_shift; go to WAIT; wb_valid=0 on that edge.
  - d_ready in this same cycle is ignored. Memory responds no earlier than the following cycle.
- WAIT, d_ready=0: remain in WAIT; stall_req stays 1; in_valid is ignored.
- WAIT, d_ready=1:
  - Next edge: wb_valid=1, wb_rd=latched rd, wb_we=(rd≠0), wb_data=extracted value; return to IDLE.
  - The instruction held upstream is accepted on the following cycle, giving one bubble.
- Extraction:
  - s = d_data_read >> (8*load_shift), zero-filled from the top.
  - LB: sign-extend s[7:0]. LBU: zero-extend s[7:0].
  - LH: sign-extend s[15:0]. LHU: zero-extend s[15:0].
  - LW: d_data_read unshifted; load_shift is ignored.
  - funct3 011, 110 or 111 is treated as LW.
  - Misaligned LH with shift=3: s[15:8]=0, so the result is zero-extended byte 3.
- d_ready in IDLE is ignored.

Optional Feature:
- Macro: LOAD_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to WAIT and increments each WAIT cycle with d_ready=0.
  - If the counter reaches TIMEOUT_CYCLES with d_ready still 0, the next edge gives: state=IDLE, wb_valid=1, wb_rd=latched rd, wb_we=0, wb_data=32'hDEAD_BEEF, load_err=1 for one cycle.
  - If d_ready arrives in the same cycle the count reaches TIMEOUT_CYCLES, d_ready wins: normal writeback, load_err=0.
- Undefined: no counter; WAIT lasts until d_ready; load_err is constant 0.

Test Plan:
- Reset mid-WAIT: LW issued, reset_n pulsed low before d_ready, then d_ready=1 -> all outputs 0, state IDLE, no wb_valid pulse.
- ADD with rd=5, res=32'h1234 -> one cycle later wb_valid=1, wb_rd=5, wb_data=32'h1234, wb_we=1. Same with rd=0 -> wb_we=0.
- LB, shift=2, d_data_read=32'h0080_FF11, d_ready after 3 cycles -> stall_req=1 for exactly 3 cycles, then wb_data=32'hFFFF_FF80, wb_we=1.
- LHU, shift=2, data=32'h8001_0000 -> wb_data=32'h0000_8001. LH with the same data -> wb_data=32'hFFFF_8001. LW, shift=1, data=32'hCAFE_BABE -> wb_data=32'hCAFE_BABE.
- Back-to-back LW then ADD, d_ready the cycle after the LW is accepted -> ADD is held one extra bubble cycle, then written back; the LW result precedes the ADD result.
- With LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4, no d_ready -> after 4 WAIT cycles: wb_data=32'hDEAD_BEEF, wb_we=0, load_err pulses once. With d_ready on the 4th cycle -> normal writeback, load_err=0.
